env_vca: RTL and testbench

Per-voice ADSR envelope generator with a built-in VCA. It sits directly downstream of the `sine` oscillator and consumes its signed sample stream every clock. It scales each sample by a 24-bit envelope that advances once per sample-rate tick, and it hands the enveloped sample to the voice mixer.

---
 rtl/env_vca.sv | 146 ++++++++++++++
 tb/tb_env_vca.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/env_vca.sv
// Per-voice ADSR envelope generator feeding a two-stage VCA on the oscillator stream.
// Optional build macro: ENV_EXP_RELEASE_EN selects an exponential-like release tail.
package constants;
  parameter int SYNTH_WIDTH = 16;
endpackage

module env_vca #(
  parameter int WIDTH     = constants::SYNTH_WIDTH,
  parameter int RATE_BITS = 24
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    tick_in,
  input  logic                    gate_in,
  input  logic [RATE_BITS-1:0]    attack_rate_in,
  input  logic [RATE_BITS-1:0]    decay_rate_in,
  input  logic [7:0]              sustain_level_in,
  input  logic [RATE_BITS-1:0]    release_rate_in,
  input  logic signed [WIDTH-1:0] sample_in,
  output logic signed [WIDTH-1:0] val_out,
  output logic [23:0]             env_out,
  output logic [2:0]              state_out,
  output logic                    active_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] env_q, env_d;
  logic        gate_q;

  logic [23:0] atk_rate, dec_rate, rel_rate, sus_tgt;
  logic [24:0] att_sum, dec_floor, rel_step;
  logic        rise, fall;

  assign atk_rate  = 24'(attack_rate_in);
  assign dec_rate  = 24'(decay_rate_in);
  assign rel_rate  = 24'(release_rate_in);
  assign sus_tgt   = {3{sustain_level_in}};
  assign rise      = gate_in & ~gate_q;
  assign fall      = ~gate_in & gate_q;
  assign att_sum   = {1'b0, env_q} + {1'b0, atk_rate};
  assign dec_floor = {1'b0, sus_tgt} + {1'b0, dec_rate};
`ifdef ENV_EXP_RELEASE_EN
  assign rel_step  = {6'd0, env_q[23:5]} + {1'b0, rel_rate};
`else
  assign rel_step  = {1'b0, rel_rate};
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      gate_q  <= gate_in;
    end
  end

  // Gate edges take priority over the tick: the envelope does not step on an edge cycle.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise) begin
      state_d = ST_ATTACK;
    end else if (fall) begin
      if (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)
        state_d = ST_RELEASE;
    end else if (tick_in) begin
      case (state_q)
        ST_IDLE: env_d = '0;
        ST_ATTACK: begin
          if (att_sum[24]) begin
            env_d   = '1;
            state_d = ST_DECAY;
          end else begin
            env_d = att_sum[23:0];
          end
        end
        ST_DECAY: begin
          if ({1'b0, env_q} <= dec_floor) begin
            env_d   = sus_tgt;
            state_d = ST_SUSTAIN;
          end else begin
            env_d = env_q - dec_rate;
          end
        end
        ST_SUSTAIN: env_d = sus_tgt;
        ST_RELEASE: begin
          if ({1'b0, env_q} <= rel_step) begin
            env_d   = '0;
            state_d = ST_IDLE;
          end else begin
            env_d = env_q - rel_step[23:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    state_out  = state_q;
    env_out    = env_q;
    active_out = (state_q != ST_IDLE);
  end

  // VCA: gain reaches exactly 0x10000 at full-scale envelope so unity passes unchanged.
  logic signed [WIDTH-1:0]  sample_s1_q;
  logic [16:0]              gain_s1_q, gain_d;
  logic signed [WIDTH-1:0]  val_q, val_d;
  logic signed [WIDTH+17:0] prod;
  logic                     prod_unused;

  assign gain_d      = {1'b0, env_q[23:8]} + {16'd0, env_q[23]};
  assign prod        = $signed({{18{sample_s1_q[WIDTH-1]}}, sample_s1_q})
                     * $signed({{(WIDTH+1){1'b0}}, gain_s1_q});
  assign val_d       = prod[WIDTH+15:16];
  assign prod_unused = ^{prod[WIDTH+17:WIDTH+16], prod[15:0]};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sample_s1_q <= '0;
      gain_s1_q   <= '0;
      val_q       <= '0;
    end else begin
      sample_s1_q <= sample_in;
      gain_s1_q   <= gain_d;
      val_q       <= val_d;
    end
  end

  assign val_out = val_q;

endmodule

// File: tb/tb_env_vca.sv
// Randomized and directed bench for env_vca against a behavioural ADSR/VCA model.
module tb_env_vca;
  localparam int W = 16;

  logic                clk_in = 1'b0;
  logic                rst_in, tick_in, gate_in;
  logic [23:0]         atk, dec, rel;
  logic [7:0]          sus;
  logic signed [W-1:0] sample_in, val_out;
  logic [23:0]         env_out;
  logic [2:0]          state_out;
  logic                active_out;

  always #5 clk_in = ~clk_in;

  env_vca #(.WIDTH(W), .RATE_BITS(24)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .tick_in(tick_in), .gate_in(gate_in),
    .attack_rate_in(atk), .decay_rate_in(dec), .sustain_level_in(sus),
    .release_rate_in(rel), .sample_in(sample_in), .val_out(val_out),
    .env_out(env_out), .state_out(state_out), .active_out(active_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: envelope as plain integers, VCA as a delayed arithmetic product.
  int     m_state;
  longint m_env, m_pend, m_val;
  bit     m_gq;

  function automatic longint vca(longint s, longint e);
    longint g;
    g = (e / 256) + ((e >= 64'h800000) ? 1 : 0);
    return (s * g) >>> 16;
  endfunction

  task automatic model_reset();
    m_state = 0; m_env = 0; m_pend = 0; m_val = 0; m_gq = 0;
  endtask

  task automatic model_clock();
    bit     rise, fall;
    longint s_tgt, step;
    rise  = gate_in && !m_gq;
    fall  = !gate_in && m_gq;
    s_tgt = longint'(sus) * 65793;
    m_val  = m_pend;
    m_pend = vca(longint'(sample_in), m_env);
    if (rise) m_state = 1;
    else if (fall) begin
      if (m_state >= 1 && m_state <= 3) m_state = 4;
    end else if (tick_in) begin
      case (m_state)
        0: m_env = 0;
        1: if (m_env + atk >= 64'h1000000) begin m_env = 64'hFFFFFF; m_state = 2; end
           else m_env = m_env + atk;
        2: if (m_env <= s_tgt + dec) begin m_env = s_tgt; m_state = 3; end
           else m_env = m_env - dec;
        3: m_env = s_tgt;
        default: begin
`ifdef ENV_EXP_RELEASE_EN
          step = m_env / 32 + rel;
`else
          step = rel;
`endif
          if (m_env <= step) begin m_env = 0; m_state = 0; end
          else m_env = m_env - step;
        end
      endcase
    end
    m_gq = gate_in;
  endtask

  task automatic cyc(input bit tk);
    tick_in = tk;
    model_clock();
    @(posedge clk_in); #1;
    tick_in = 1'b0;
    check("env", env_out, m_env);
    check("state", state_out, m_state);
    check("active", active_out, (m_state != 0));
    check("val", val_out, m_val);
  endtask

  task automatic tick4();
    cyc(0); cyc(0); cyc(0); cyc(1);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
  endtask

  initial begin
    longint rel_exp [5];
    rel_exp = '{64'h304040, 64'h204040, 64'h104040, 64'h004040, 64'h0};
    tick_in = 0; gate_in = 0; atk = 0; dec = 0; rel = 0; sus = 0;
    sample_in = 16'sh4000;
    do_reset();
    check("rst_val", val_out, 0);
    check("rst_state", state_out, 0);
    check("rst_active", active_out, 0);
    check("rst_env", env_out, 0);
    repeat (4) cyc(0);
    check("idle_val", val_out, 0);
    $display("reset/idle: val=%0h state=%0d", val_out, state_out);

    atk = 24'h100000; dec = 24'h080000; sus = 8'h80; rel = 24'h100000;
    gate_in = 1;
    for (int t = 1; t <= 16; t++) begin
      tick4();
      if (t == 15) check("att_t15", env_out, 64'hF00000);
    end
    check("att_t16_env", env_out, 64'hFFFFFF);
    check("att_t16_state", state_out, 2);
    $display("attack done: env=%h state=%0d", env_out, state_out);
    sample_in = 16'sh4000;
    cyc(0); cyc(0);
    check("unity_val", val_out, 64'h4000);
    $display("unity: val=%h", val_out);

    for (int t = 1; t <= 16; t++) begin
      tick4();
      if (t == 15) check("dec_t15_state", state_out, 2);
    end
    check("sus_env", env_out, 64'h808080);
    check("sus_state", state_out, 3);
    sus = 8'h40;
    tick4();
    check("sus_track", env_out, 64'h404040);
    $display("sustain: env=%h", env_out);

    gate_in = 0;
    cyc(0);
    check("rel_state", state_out, 4);
    for (int t = 0; t < 5; t++) begin
      tick4();
`ifndef ENV_EXP_RELEASE_EN
      check("rel_env", env_out, rel_exp[t]);
`endif
      $display("release tick %0d: env=%h state=%0d", t + 1, env_out, state_out);
    end
`ifndef ENV_EXP_RELEASE_EN
    check("rel_idle", state_out, 0);
`endif

    // Second note: retrigger from RELEASE at 0x204040 with a coincident tick.
    cyc(0); cyc(0);
    gate_in = 1;
    cyc(1);
    check("rise_tick_state", state_out, 1);
    for (int t = 0; t < 16; t++) tick4();
    for (int t = 0; t < 64 && state_out != 3; t++) tick4();
    check("note2_sus", env_out, 64'h404040);
    gate_in = 0;
    cyc(0);
    tick4(); tick4();
`ifndef ENV_EXP_RELEASE_EN
    check("retrig_pre", env_out, 64'h204040);
`endif
    cyc(0); cyc(0);
    gate_in = 1;
    cyc(1);
    check("retrig_state", state_out, 1);
`ifndef ENV_EXP_RELEASE_EN
    check("retrig_env", env_out, 64'h204040);
    tick4();
    check("retrig_step", env_out, 64'h304040);
`endif
    $display("retrigger: env=%h state=%0d", env_out, state_out);

    // Asynchronous reset mid-release, gate held high across reset release.
    gate_in = 0;
    cyc(0);
    tick4();
    check("pre_async_state", state_out, 4);
    #2 rst_in = 1'b0;
    gate_in = 1;
    #1;
    check("async_env", env_out, 0);
    check("async_state", state_out, 0);
    check("async_active", active_out, 0);
    check("async_val", val_out, 0);
    model_reset();
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    cyc(0);
    check("post_rst_rise", state_out, 1);
    $display("async reset: state after release=%0d", state_out);

`ifdef ENV_EXP_RELEASE_EN
    gate_in = 0;
    do_reset();
    atk = 24'h100000; rel = 24'h0;
    gate_in = 1;
    for (int t = 0; t < 8; t++) tick4();
    check("exp_pre", env_out, 64'h800000);
    gate_in = 0;
    cyc(0);
    tick4();
    check("exp_step", env_out, 64'h7C0000);
    $display("exp release: env=%h", env_out);
`endif

    gate_in = 0;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        atk = 24'($urandom >> $urandom_range(8, 28));
        dec = 24'($urandom >> $urandom_range(8, 28));
        rel = 24'($urandom >> $urandom_range(8, 28));
      end
      if (c % 50 == 0) sus = 8'($urandom);
      if ($urandom_range(0, 39) == 0) gate_in = ~gate_in;
      sample_in = W'($urandom);
      cyc($urandom_range(0, 3) == 0);
    end
    $display("random phase: %0d cycles done", 4000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
